// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the control unit and the multiply/divide unit.
// The control unit drives the start levels and operands; the unit returns HI/LO and status.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             MULTcontrol;
  logic             DIVcontrol;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Busy;
  logic             Done;
  logic             Div0;

  modport master (output MULTcontrol, DIVcontrol, A, B,
                  input  HI, LO, Busy, Done, Div0);
  modport slave  (input  MULTcontrol, DIVcontrol, A, B,
                  output HI, LO, Busy, Done, Div0);
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// One iteration per cycle; 64-bit result in HI/LO with a single-cycle Done strobe.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int W = WIDTH;

  typedef enum logic [1:0] {IDLE, RUN_MULT, RUN_DIV, FINISH} state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  // acc: Booth accumulator (mult) or partial remainder (div); q: multiplier or quotient
  logic [W:0]     acc_q, acc_d;
  logic [W-1:0]   q_q, q_d;
  logic           qm1_q, qm1_d;
  logic [W:0]     m_q, m_d;
  logic           is_div_q, is_div_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           div0_q, div0_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           div0_out_q, div0_out_d;

  logic [W:0]     booth_sum;
  logic [W:0]     rem_sh, rem_diff;
  logic [W-1:0]   a_abs, b_abs;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      is_div_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div0_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      qm1_q      <= qm1_d;
      m_q        <= m_d;
      is_div_q   <= is_div_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div0_q     <= div0_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div0_out_q <= div0_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.MULTcontrol)     state_d = RUN_MULT;
        else if (bus.DIVcontrol) state_d = (bus.B == '0) ? FINISH : RUN_DIV;
      end
      RUN_MULT, RUN_DIV: if (cnt_q == 6'(W-1)) state_d = FINISH;
      FINISH:            state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    a_abs = bus.A[W-1] ? -bus.A : bus.A;
    b_abs = bus.B[W-1] ? -bus.B : bus.B;

    unique case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase

    // Remainder stays below |B| <= 2^(W-1), so W+1 bits hold the trial difference's sign.
    rem_sh   = {acc_q[W-1:0], q_q[W-1]};
    rem_diff = rem_sh - m_q;

    cnt_d      = cnt_q;
    acc_d      = acc_q;
    q_d        = q_q;
    qm1_d      = qm1_q;
    m_d        = m_q;
    is_div_d   = is_div_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div0_d     = div0_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div0_out_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.MULTcontrol || bus.DIVcontrol) begin
          cnt_d  = '0;
          acc_d  = '0;
          qm1_d  = 1'b0;
          busy_d = 1'b1;
          if (bus.MULTcontrol) begin
            q_d      = bus.B;
            m_d      = {bus.A[W-1], bus.A};
            is_div_d = 1'b0;
            div0_d   = 1'b0;
          end else begin
            q_d       = a_abs;
            m_d       = {1'b0, b_abs};
            is_div_d  = 1'b1;
            neg_quo_d = bus.A[W-1] ^ bus.B[W-1];
            neg_rem_d = bus.A[W-1];
            div0_d    = (bus.B == '0);
          end
        end
      end
      RUN_MULT: begin
        acc_d = {booth_sum[W], booth_sum[W:1]};
        q_d   = {booth_sum[0], q_q[W-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + 6'd1;
      end
      RUN_DIV: begin
        if (!rem_diff[W]) begin
          acc_d = rem_diff;
          q_d   = {q_q[W-2:0], 1'b1};
        end else begin
          acc_d = rem_sh;
          q_d   = {q_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
      end
      FINISH: begin
        cnt_d      = '0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        div0_out_d = div0_q;
        if (!div0_q) begin
          if (is_div_q) begin
            hi_d = neg_rem_q ? -acc_q[W-1:0] : acc_q[W-1:0];
            lo_d = neg_quo_q ? -q_q : q_q;
          end else begin
            hi_d = acc_q[W-1:0];
            lo_d = q_q;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Div0 = div0_out_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/Div0/latency queued at issue,
// compared when Done strobes.
module tb_mult_div_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mult_div_unit_if #(.WIDTH(32)) bus ();
  mult_div_unit #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          lat;
    int          start;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  logic        prev_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Result monitor
  always @(negedge clock) begin
    if (bus.Done === 1'b1) begin
      exp_t e;
      chk("done_pulse", 64'(prev_done), 64'd0);
      if (sbq.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("hi",      64'(bus.HI),   64'(e.hi));
        chk("lo",      64'(bus.LO),   64'(e.lo));
        chk("div0",    64'(bus.Div0), 64'(e.div0));
        chk("latency", 64'(cyc - e.start), 64'(e.lat));
        chk("busy_at_done", 64'(bus.Busy), 64'd0);
      end
    end
    prev_done = (bus.Done === 1'b1);
  end

  // Drives start for one edge, then scrambles operands to prove they were captured.
  task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input bit ediv0,
                       input int elat, input bit push);
    exp_t e;
    bus.MULTcontrol = m;
    bus.DIVcontrol  = d;
    bus.A = a;
    bus.B = b;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.div0 = ediv0; e.lat = elat; e.start = cyc + 1;
      sbq.push_back(e);
      if (!ediv0) begin last_hi = ehi; last_lo = elo; end
    end
    @(posedge clock);
    #1;
    bus.MULTcontrol = 1'b0;
    bus.DIVcontrol  = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    @(negedge clock);
    chk("busy_run", 64'(bus.Busy), 64'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.Done !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (bus.Done !== 1'b1) chk("timeout", 64'd0, 64'd1);
  endtask

  task automatic do_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    issue(1'b1, 1'b0, a, b, p[63:32], p[31:0], 1'b0, 33, 1'b1);
    wait_done();
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b);
    int sa, sb, qq, rr;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      issue(1'b0, 1'b1, a, b, last_hi, last_lo, 1'b1, 1, 1'b1);
    end else begin
      if (sa == 32'sh80000000 && sb == -1) begin qq = sa; rr = 0; end
      else begin qq = sa / sb; rr = sa % sb; end
      issue(1'b0, 1'b1, a, b, rr, qq, 1'b0, 33, 1'b1);
    end
    wait_done();
  endtask

  initial begin
    bus.MULTcontrol = 1'b0;
    bus.DIVcontrol  = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(negedge clock);
    chk("reset_outs", {bus.HI, bus.LO}, 64'd0);
    chk("reset_flags", {61'd0, bus.Busy, bus.Done, bus.Div0}, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      chk("idle_outs", {bus.HI ^ bus.LO, 29'd0, bus.Busy, bus.Done, bus.Div0}, 64'd0);
    end

    // Reference vectors with hand-computed results; back-to-back issue
    issue(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b1);
    wait_done();
    issue(1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 33, 1'b1);
    wait_done();
    issue(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b1);
    wait_done();
    issue(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33, 1'b1);
    wait_done();

    // Divide by zero after a multiply: HI/LO keep the product
    do_mult(32'd123456, 32'hFFFF0001);
    do_div(32'd99, 32'd0);

    // Both starts high: multiply wins
    issue(1'b1, 1'b1, 32'd6, 32'd4, 32'd0, 32'd24, 1'b0, 33, 1'b1);
    wait_done();

    // DIVcontrol pulse during a running multiply is ignored
    @(negedge clock);
    begin
      longint p;
      p = longint'($signed(32'hFFFFF000)) * longint'($signed(32'd77777));
      issue(1'b1, 1'b0, 32'hFFFFF000, 32'd77777, p[63:32], p[31:0], 1'b0, 33, 1'b1);
    end
    repeat (9) @(negedge clock);
    bus.DIVcontrol = 1'b1;
    @(negedge clock);
    bus.DIVcontrol = 1'b0;
    wait_done();

    for (int i = 0; i < 5; i++) do_mult($urandom, $urandom);
    for (int i = 0; i < 5; i++) do_div($urandom, $urandom_range(1, 32'h7FFFFFFF) * ((i % 2) ? -1 : 1));
    do_div(32'hFFFFFFF9, 32'd2);
    do_div(32'd7, 32'hFFFFFFFE);

    // Reset mid-multiply aborts with no Done
    @(negedge clock);
    issue(1'b1, 1'b0, 32'd1234, 32'd5678, 32'd0, 32'd0, 1'b0, 33, 1'b0);
    repeat (19) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("abort_outs", {bus.HI, bus.LO}, 64'd0);
    chk("abort_flags", {61'd0, bus.Busy, bus.Done, bus.Div0}, 64'd0);
    last_hi = '0;
    last_lo = '0;
    repeat (40) @(negedge clock);
    chk("abort_no_done", 64'(sbq.size()), 64'd0);

    // Div0 straight after reset: HI/LO stay zero
    do_div(32'd5, 32'd0);
    do_mult(32'd6, 32'd7);

    repeat (3) @(negedge clock);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
